seq_mac_accumulator: RTL

- Downstream consumer of the 16x16 signed sequential multiplier.
- Takes each signed 32-bit product the multiplier delivers with its done indication and accumulates a programmable number of them into a sign-extended accumulator.
- Emits the finished dot-product sum with a one-cycle valid pulse and a sticky overflow flag.
- Sits between the multiplier and the result-collection logic of the MAC datapath.

---
 rtl/seq_mac_accumulator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_mac_accumulator.sv
// Accumulates a programmable number of signed multiplier products into a wide sum.
// Result is registered on the edge that samples the final product's done rising edge.
// No backpressure: acc_valid is a single-cycle pulse that the consumer must take.
module seq_mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              acc_ovf,
    output logic              busy,
    output logic [CNT_W-1:0]  term_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               hist;
    logic               ev;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_eff;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic               ovf_q;
    logic               ovf_add;
    logic               done;
    logic [ACC_W-1:0]   fin_sum;
    logic               fin_ovf;

    // Product event is the rising edge of the multiplier's level done signal.
    assign ev       = prod_valid & ~hist;
    assign prod_ext = ACC_W'($signed(prod_in));
    assign len_eff  = (len == '0) ? CNT_W'(1) : len;
    assign sum      = acc + prod_ext;
    // Same-sign operands producing a differently signed result means wrap-around.
    assign ovf_add  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign busy     = (state == ACCUM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and completion decode; clear beats any coincident product.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        fin_sum   = sum;
        fin_ovf   = ovf_q | ovf_add;
        if (state == IDLE) begin
            fin_sum = prod_ext;
            fin_ovf = 1'b0;
        end
        if (clear) begin
            state_nxt = IDLE;
        end else if (ev) begin
            case (state)
                IDLE: begin
                    if (len_eff == CNT_W'(1)) begin
                        done = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if ((term_cnt + CNT_W'(1)) == len_q) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Done history starts high so a done held across reset is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 1'b1;
        end else begin
            hist <= prod_valid;
        end
    end

    // Accumulator datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            term_cnt  <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            acc_ovf   <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (clear) begin
                acc      <= '0;
                term_cnt <= '0;
                ovf_q    <= 1'b0;
            end else if (ev) begin
                if (state == IDLE) begin
                    len_q <= len_eff;
                end
                if (done) begin
                    acc_out   <= fin_sum;
                    acc_ovf   <= fin_ovf;
                    acc_valid <= 1'b1;
                    acc       <= '0;
                    term_cnt  <= '0;
                    ovf_q     <= 1'b0;
                end else if (state == IDLE) begin
                    acc      <= prod_ext;
                    term_cnt <= CNT_W'(1);
                    ovf_q    <= 1'b0;
                end else begin
                    acc      <= sum;
                    term_cnt <= term_cnt + CNT_W'(1);
                    ovf_q    <= ovf_q | ovf_add;
                end
            end
        end
    end

endmodule
